vend_change_dispenser: RTL and testbench
========================================

// Module: vend_change_dispenser
// PURPOSE
//  Downstream consumer of the vending FSM's out/change outputs.
//  Queues each vend/change request and drives the product motor and coin-hopper solenoid with timed pulses.
//  Confirms each returned coin through the hopper sensor and flags a jam on timeout.
//  Sits between the vending FSM and the physical actuators.
// PARAMETERS
//  PULSE_CYCLES   4   width of every eject pulse, in clk cycles (>=1)
//  TIMEOUT_CYCLES 64  cycles to wait in COIN_WAIT for coin_sensed before jam
//  QDEPTH         4   request queue depth (power of 2, >=2)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  vend_in      in   1  product-vend strobe (vending FSM out), one request per high cycle
//  change_in    in   2  coins owed in 5-unit coins (0..3), valid same cycle as strobe
//  coin_sensed  in   1  hopper optical sensor pulse, one per coin passed
//  jam_clr      in   1  operator clear of jam condition
//  product_eject out 1  product motor pulse
//  coin_eject   out  1  hopper solenoid pulse, one per coin
//  busy         out  1  FSM not IDLE or queue non-empty
//  jam          out  1  sticky timeout error
//  q_overflow   out  1  sticky: request dropped, queue full
//  coins_paid   out  8  running total of confirmed coins, wraps 255->0
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; queue emptied; FSM IDLE.
//   - rst mid-operation aborts the current pulse the same cycle and discards pending coins.
//  Enqueue:
//   - any cycle with vend_in=1 or change_in!=0 pushes {vend_in, change_in}.
//   - a {0,00} request is never queued.
//  Queue full:
//   - push accepted if count<QDEPTH, or if a pop occurs the same cycle.
//   - otherwise the request is dropped and q_overflow is set; it stays set until rst.
//  FSM states: IDLE, PROD, COIN_PULSE, COIN_WAIT, JAM. Outputs decode registered state.
//   - IDLE: queue non-empty -> pop. vend bit=1 -> PROD; else -> COIN_PULSE with remaining=change.
//   - PROD: product_eject=1 for exactly PULSE_CYCLES cycles; then remaining!=0 -> COIN_PULSE, else -> IDLE.
//   - COIN_PULSE: coin_eject=1 for PULSE_CYCLES cycles -> COIN_WAIT; timeout counter cleared.
//   - COIN_WAIT: coin_sensed=1 -> remaining-1 and coins_paid+1; then remaining!=0 -> COIN_PULSE, else -> IDLE.
//     If TIMEOUT_CYCLES elapse without coin_sensed -> JAM.
//     coin_sensed on the final timeout cycle counts as success; no jam.
//   - JAM: jam=1, no ejects. jam_clr -> IDLE, remaining coins of the current entry discarded.
//     jam stays 1 until that transition.
//  Queue behaviour in JAM: still accepts pushes.
//  coin_sensed: ignored in every state except COIN_WAIT.
//  Latency: request at cycle N into an idle, empty block -> product_eject (or coin_eject) high on cycles N+2..N+1+PULSE_CYCLES.
//  Back-to-back: one IDLE cycle separates consecutive queue entries.
// CONFIGURATION
//  VEND_STATS_EN defined:
//   - coins_paid counter implemented as above.
//  VEND_STATS_EN undefined:
//   - no counter flops; coins_paid tied to 8'd0.
//   - all other behaviour identical.
// STRUCTURE
//  vend_defs.vh (shared with the vending FSM):
//   - FSM state localparams.
//   - change code width and coin-value constant.
//  Sub-module vend_req_fifo: QDEPTH x 3-bit synchronous FIFO.
//   - ports: push, pop, din, dout, full, empty; same clk/rst.
//  Top level: FSM, pulse counter, timeout counter, remaining-coin counter, stats counter.
// TESTING
//  1. vend_in=1, change_in=0 for one cycle -> product_eject high exactly 4 cycles starting 2 cycles later; coin_eject never asserts; busy drops after.
//  2. vend_in=1, change_in=2; coin_sensed pulsed 3 cycles into each COIN_WAIT
//     -> one product pulse, then two coin_eject pulses; coins_paid=2; jam=0.
//  3. change_in=1, coin_sensed held 0 -> jam rises after 64 COIN_WAIT cycles.
//     jam_clr -> jam=0, IDLE; a queued follow-up request is then serviced.
//  4. Six requests on consecutive cycles with FSM busy -> first 5 accepted (1 popped + 4 queued); 6th dropped; q_overflow=1.
//  5. rst asserted mid coin_eject pulse -> next cycle all outputs 0, busy=0, queue empty.
//  6. coin_sensed on the 64th COIN_WAIT cycle -> no jam; coins_paid increments.
//     Also: sense pulses during COIN_PULSE are ignored.

Source files
------------

// File: rtl/vend_change_dispenser_pkg.sv
// -----------------------------------------------------------------------------
// vend_change_dispenser_pkg
// Shared definitions for the change dispenser and the vending FSM that feeds it:
// FSM state encoding, request word layout, and change-code constants.
// No ports (package).
// -----------------------------------------------------------------------------
package vend_change_dispenser_pkg;

    // Change is encoded as a count of coins of COIN_VALUE units each.
    localparam int CHANGE_W   = 2;
    localparam int COIN_VALUE = 5;
    localparam int REQ_W      = CHANGE_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROD,
        ST_COIN_PULSE,
        ST_COIN_WAIT,
        ST_JAM
    } state_e;

    // One queued request: product strobe plus coins owed.
    typedef struct packed {
        logic                vend;
        logic [CHANGE_W-1:0] change;
    } req_t;

endpackage

// File: rtl/vend_change_dispenser_req_fifo.sv
// -----------------------------------------------------------------------------
// vend_req_fifo
// DEPTH x WIDTH synchronous FIFO with first-word-fall-through read (dout shows
// the head entry whenever empty=0). A push is accepted when not full, or when
// a pop happens in the same cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write strobe and data
//   pop, dout     read strobe and head data
//   full, empty   occupancy flags
// -----------------------------------------------------------------------------
module vend_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // NOTE: every path assigns count_d up front so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// -----------------------------------------------------------------------------
// vend_change_dispenser
// Queues vend/change requests from the vending FSM and drives the product motor
// and coin-hopper solenoid with fixed-width pulses. Each coin is confirmed by
// the hopper sensor; a missing confirmation within TIMEOUT_CYCLES raises jam.
// Configuration macro: VEND_STATS_EN (defined -> coins_paid counter present,
// undefined -> coins_paid tied to zero).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   vend_in        product-vend strobe, one request per high cycle
//   change_in      coins owed (0..3), valid with the strobe
//   coin_sensed    hopper sensor pulse, one per coin passed
//   jam_clr        operator clear of the jam condition
//   product_eject  product motor pulse
//   coin_eject     hopper solenoid pulse, one per coin
//   busy           FSM active or requests pending
//   jam            sticky timeout error, cleared by jam_clr
//   q_overflow     sticky: a request was dropped on a full queue
//   coins_paid     wrapping count of confirmed coins
// -----------------------------------------------------------------------------
module vend_change_dispenser
    import vend_change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int QDEPTH         = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vend_in,
    input  logic [CHANGE_W-1:0] change_in,
    input  logic                coin_sensed,
    input  logic                jam_clr,
    output logic                product_eject,
    output logic                coin_eject,
    output logic                busy,
    output logic                jam,
    output logic                q_overflow,
    output logic [7:0]          coins_paid
);

    localparam int            PW         = $clog2(PULSE_CYCLES) + 1;
    localparam int            TW         = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [PW-1:0]       pulse_q, pulse_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [CHANGE_W-1:0] rem_q, rem_d;
    logic                ovf_q;

    logic                push_req, pop;
    logic                fifo_full, fifo_empty;
    logic [REQ_W-1:0]    fifo_dout;
    req_t                head;

    // A {0,00} request carries nothing to dispense and is never queued.
    assign push_req = vend_in || (change_in != '0);
    assign head     = req_t'(fifo_dout);

    vend_req_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   ({vend_in, change_in}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        tmo_d   = tmo_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    pulse_d = '0;
                    rem_d   = head.change;
                    state_d = head.vend ? ST_PROD : ST_COIN_PULSE;
                end
            end
            ST_PROD: begin
                if (pulse_q == PULSE_LAST) begin
                    pulse_d = '0;
                    state_d = (rem_q != '0) ? ST_COIN_PULSE : ST_IDLE;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            ST_COIN_PULSE: begin
                if (pulse_q == PULSE_LAST) begin
                    pulse_d = '0;
                    tmo_d   = '0;
                    state_d = ST_COIN_WAIT;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            ST_COIN_WAIT: begin
                // Sensing wins over the timeout, even on the final wait cycle.
                if (coin_sensed) begin
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q != CHANGE_W'(1)) ? ST_COIN_PULSE : ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_JAM;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_JAM: begin
                if (jam_clr) begin
                    rem_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pulse_q <= '0;
            tmo_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            tmo_q   <= tmo_d;
            rem_q   <= rem_d;
            // A pop in the same cycle frees a slot, so only a full, non-popping
            // queue drops the request.
            if (push_req && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    assign product_eject = (state_q == ST_PROD);
    assign coin_eject    = (state_q == ST_COIN_PULSE);
    assign jam           = (state_q == ST_JAM);
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;
    assign q_overflow    = ovf_q;

`ifdef VEND_STATS_EN
    logic [7:0] paid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            paid_q <= '0;
        end else if (state_q == ST_COIN_WAIT && coin_sensed) begin
            paid_q <= paid_q + 1'b1;
        end
    end

    assign coins_paid = paid_q;
`else
    assign coins_paid = 8'd0;
`endif

endmodule

// File: tb/tb_vend_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_vend_change_dispenser
// Directed bench for vend_change_dispenser. Stimulus pushes the expected eject
// pulses (kind + width) into a queue; a monitor measures every pulse the DUT
// produces and pops/compares. Level checks (jam, busy, flags) are inline.
// -----------------------------------------------------------------------------
module tb_vend_change_dispenser;

    localparam int PULSE   = 4;
    localparam int TIMEOUT = 64;
    localparam int K_PROD  = 1;
    localparam int K_COIN  = 2;
    localparam int S_PROD  = 0;
    localparam int S_COIN  = 1;
    localparam int S_JAM   = 2;
    localparam int S_BUSY  = 3;

    typedef struct {
        int kind;
        int width;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vend_in = 1'b0;
    logic [1:0] change_in = 2'd0;
    logic       coin_sensed = 1'b0;
    logic       jam_clr = 1'b0;
    logic       product_eject, coin_eject, busy, jam, q_overflow;
    logic [7:0] coins_paid;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     exp_paid = 0;
    pulse_t exp_q[$];

    vend_change_dispenser #(
        .PULSE_CYCLES   (PULSE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .QDEPTH         (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vend_in       (vend_in),
        .change_in     (change_in),
        .coin_sensed   (coin_sensed),
        .jam_clr       (jam_clr),
        .product_eject (product_eject),
        .coin_eject    (coin_eject),
        .busy          (busy),
        .jam           (jam),
        .q_overflow    (q_overflow),
        .coins_paid    (coins_paid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int paid_model();
`ifdef VEND_STATS_EN
        return exp_paid & 255;
`else
        return 0;
`endif
    endfunction

    task automatic expect_pulse(input int kind, input int width);
        pulse_t p;
        p.kind  = kind;
        p.width = width;
        exp_q.push_back(p);
    endtask

    // Wait (sampling on negedges, current cycle included) for a signal level.
    task automatic wait_sig(input int which, input logic lvl, input string name);
        logic cur;
        bit   found = 0;
        for (int n = 0; n < 500 && !found; n++) begin
            @(negedge clk);
            case (which)
                S_PROD:  cur = product_eject;
                S_COIN:  cur = coin_eject;
                S_JAM:   cur = jam;
                default: cur = busy;
            endcase
            if (cur === lvl) found = 1;
        end
        if (!found) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_sense_at_wait_cycle(input int c);
        repeat (c - 1) @(posedge clk);
        #1 coin_sensed = 1'b1;
        @(posedge clk);
        #1 coin_sensed = 1'b0;
    endtask

    // Monitor: measure each eject pulse and compare against the scoreboard.
    int mon_kind = 0;
    int mon_w    = 0;
    always @(negedge clk) begin
        int     k;
        pulse_t e;
        k = product_eject ? K_PROD : (coin_eject ? K_COIN : 0);
        if (product_eject && coin_eject) check("both_ejects", 1, 0);
        if (mon_kind != 0 && k == mon_kind) begin
            mon_w++;
        end else begin
            if (mon_kind != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", mon_kind, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", mon_kind, e.kind);
                    check("pulse_width", mon_w, e.width);
                end
            end
            mon_kind = k;
            mon_w    = (k != 0) ? 1 : 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_product", product_eject, 0);
        check("rst_coin", coin_eject, 0);
        check("rst_busy", busy, 0);
        check("rst_jam", jam, 0);
        check("rst_ovf", q_overflow, 0);
        check("rst_paid", coins_paid, 0);

        // 1: vend only; product pulse on N+2..N+5.
        @(posedge clk);
        #1 vend_in = 1'b1;
        expect_pulse(K_PROD, PULSE);
        @(negedge clk);
        check("t1_lat_c0", product_eject, 0);
        @(posedge clk);
        #1 vend_in = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("t1_prod_lvl", product_eject, (i >= 2 && i <= 5) ? 1 : 0);
            check("t1_no_coin", coin_eject, 0);
        end
        check("t1_busy_drop", busy, 0);

        // 2: vend + 2 coins, sensor 3 cycles into each wait.
        @(posedge clk);
        #1 vend_in = 1'b1; change_in = 2'd2;
        expect_pulse(K_PROD, PULSE);
        expect_pulse(K_COIN, PULSE);
        expect_pulse(K_COIN, PULSE);
        @(posedge clk);
        #1 vend_in = 1'b0; change_in = 2'd0;
        for (int c = 0; c < 2; c++) begin
            wait_sig(S_COIN, 1'b1, "t2_coin_hi");
            wait_sig(S_COIN, 1'b0, "t2_coin_lo");
            pulse_sense_at_wait_cycle(3);
            exp_paid++;
        end
        wait_sig(S_BUSY, 1'b0, "t2_idle");
        check("t2_paid", coins_paid, paid_model());
        check("t2_jam", jam, 0);

        // 3: one coin, no sensor -> jam after 64 wait cycles; then clear.
        @(posedge clk);
        #1 change_in = 2'd1;
        expect_pulse(K_COIN, PULSE);
        @(posedge clk);
        #1 change_in = 2'd0;
        wait_sig(S_COIN, 1'b1, "t3_coin_hi");
        wait_sig(S_COIN, 1'b0, "t3_coin_lo");
        repeat (TIMEOUT - 1) @(negedge clk);
        check("t3_no_jam_c64", jam, 0);
        @(negedge clk);
        check("t3_jam_c65", jam, 1);
        @(posedge clk);
        #1 vend_in = 1'b1;
        expect_pulse(K_PROD, PULSE);
        @(posedge clk);
        #1 vend_in = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_jam_sticky", jam, 1);
        check("t3_busy", busy, 1);
        @(posedge clk);
        #1 jam_clr = 1'b1;
        @(posedge clk);
        #1 jam_clr = 1'b0;
        @(negedge clk);
        check("t3_jam_clr", jam, 0);
        wait_sig(S_BUSY, 1'b0, "t3_idle");
        check("t3_paid", coins_paid, paid_model());

        // 4: six requests back to back; sixth dropped.
        check("t4_ovf_before", q_overflow, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 vend_in = 1'b1;
            if (i < 5) expect_pulse(K_PROD, PULSE);
        end
        @(posedge clk);
        #1 vend_in = 1'b0;
        @(negedge clk);
        check("t4_ovf", q_overflow, 1);
        wait_sig(S_BUSY, 1'b0, "t4_idle");
        check("t4_ovf_sticky", q_overflow, 1);

        // 5: reset during a coin pulse with a request still queued.
        @(posedge clk);
        #1 change_in = 2'd2;
        @(posedge clk);
        #1 change_in = 2'd0; vend_in = 1'b1;
        @(posedge clk);
        #1 vend_in = 1'b0;
        expect_pulse(K_COIN, 2);
        wait_sig(S_COIN, 1'b1, "t5_coin_hi");
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_paid = 0;
        check("t5_coin", coin_eject, 0);
        check("t5_product", product_eject, 0);
        check("t5_busy", busy, 0);
        check("t5_jam", jam, 0);
        check("t5_ovf", q_overflow, 0);
        check("t5_paid", coins_paid, paid_model());
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_queue_empty", busy, 0);

        // 6: sense during pulse ignored; sense on the 64th wait cycle succeeds.
        @(posedge clk);
        #1 change_in = 2'd1;
        expect_pulse(K_COIN, PULSE);
        @(posedge clk);
        #1 change_in = 2'd0;
        wait_sig(S_COIN, 1'b1, "t6_coin_hi");
        @(posedge clk);
        #1 coin_sensed = 1'b1;
        @(posedge clk);
        #1 coin_sensed = 1'b0;
        wait_sig(S_COIN, 1'b0, "t6_coin_lo");
        check("t6_paid_ignored", coins_paid, paid_model());
        pulse_sense_at_wait_cycle(TIMEOUT);
        exp_paid++;
        @(negedge clk);
        check("t6_no_jam", jam, 0);
        check("t6_idle", busy, 0);
        check("t6_paid", coins_paid, paid_model());

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
